// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
// Holds the start-code and md_wr encodings, the default operation latencies
// (the hazard unit uses these too), the controller state type and small
// decode helpers.
package md_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;

    localparam logic [1:0] MD_WR_NONE = 2'b00;
    localparam logic [1:0] MD_WR_HI   = 2'b01;
    localparam logic [1:0] MD_WR_LO   = 2'b10;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_CNT_W       = 4;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Codes 5..7 are reserved and must not start anything.
    function automatic logic md_is_op(input logic [2:0] code);
        return (code >= MD_MULT) && (code <= MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [2:0] code);
        return (code == MD_DIV) || (code == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath.
// Ports:
//   op    in  3   start code of the operation (MD_* from md_pkg)
//   a, b  in  32  operands (multiplicand/dividend, multiplier/divisor)
//   hi    out 32  upper product half or remainder
//   lo    out 32  lower product half or quotient
//   div0  out 1   divide op with a zero divisor; result must be discarded
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               ovf;
    logic        [31:0] b_div;
    logic signed [31:0] a_s;
    logic signed [31:0] b_div_s;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign div0 = md_is_div(op) && (b == 32'd0);
    assign ovf  = (op == MD_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Dividing by 1 instead of 0 keeps the divider defined (result is dropped
    // via div0), and for the signed overflow case a/1 yields exactly the
    // required quotient 0x80000000 with remainder 0.
    assign b_div   = (b == 32'd0 || ovf) ? 32'd1 : b;
    assign a_s     = $signed(a);
    assign b_div_s = $signed(b_div);

    // SystemVerilog signed / and % truncate toward zero, remainder takes the
    // dividend's sign, which is the MIPS definition.
    assign q_s = a_s / b_div_s;
    assign r_s = a_s % b_div_s;
    assign q_u = a / b_div;
    assign r_u = a % b_div;

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MD_MULT:  begin hi = prod_s[63:32]; lo = prod_s[31:0]; end
            MD_MULTU: begin hi = prod_u[63:32]; lo = prod_u[31:0]; end
            MD_DIV:   begin hi = r_s;           lo = q_s;          end
            MD_DIVU:  begin hi = r_u;           lo = q_u;          end
            default:  begin hi = 32'd0;         lo = 32'd0;        end
        endcase
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle multiply/divide controller for the E stage.
// Accepts mult/multu/div/divu starts, holds busy for a fixed latency, then
// commits the result to HI/LO. Also services mthi/mtlo and mfhi/mflo.
// Ports:
//   clk       in  1   clock
//   reset_n   in  1   synchronous active-low reset
//   start     in  3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5-7 ignored
//   md_a      in  32  rs operand
//   md_b      in  32  rt operand
//   md_wr     in  2   01 mthi, 10 mtlo
//   md_wdata  in  32  mthi/mtlo data
//   rd_hi     in  1   1 reads HI onto md_out, 0 reads LO
//   busy      out 1   operation in flight
//   hi, lo    out 32  architectural HI/LO
//   md_out    out 32  mfhi/mflo read data (combinational)
module mult_div_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  start,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic [1:0]  md_wr,
    input  logic [31:0] md_wdata,
    input  logic        rd_hi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]          op_q,    op_d;
    logic [31:0]         a_q,     a_d;
    logic [31:0]         b_q,     b_d;
    logic [31:0]         hi_q,    hi_d;
    logic [31:0]         lo_q,    lo_d;

    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_div0;

    md_calc u_calc (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi   (calc_hi),
        .lo   (calc_lo),
        .div0 (calc_div0)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                // A start takes priority; a same-cycle mthi/mtlo is dropped.
                if (md_is_op(start)) begin
                    op_d    = start;
                    a_d     = md_a;
                    b_d     = md_b;
                    cnt_d   = md_is_div(start) ? MD_CNT_W'(DIV_CYCLES)
                                               : MD_CNT_W'(MULT_CYCLES);
                    state_d = MD_RUN;
                end else if (md_wr == MD_WR_HI) begin
                    hi_d = md_wdata;
                end else if (md_wr == MD_WR_LO) begin
                    lo_d = md_wdata;
                end
            end
            MD_RUN: begin
                // start/md_wr are deliberately not looked at here.
                cnt_d = cnt_q - MD_CNT_W'(1);
                if (cnt_q == MD_CNT_W'(1)) begin
                    state_d = MD_IDLE;
                    if (!calc_div0) begin
                        hi_d = calc_hi;
                        lo_d = calc_lo;
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand/op latches are only meaningful while RUN, so no reset.
    always_ff @(posedge clk) begin
        op_q <= op_d;
        a_q  <= a_d;
        b_q  <= b_d;
    end

    assign busy   = (state_q == MD_RUN);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl with hand-computed expected values.
module tb_mult_div_ctrl;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  start;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic [1:0]  md_wr;
    logic [31:0] md_wdata;
    logic        rd_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    int checks = 0;
    int errors = 0;

    mult_div_ctrl dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_wr    (md_wr),
        .md_wdata (md_wdata),
        .rd_hi    (rd_hi),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, count the busy window, then check HI/LO and both reads.
    // With inject set, junk is applied on the bus during the first busy cycles.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] eh, input logic [31:0] el,
                         input bit inject);
        int cnt;
        start = op;
        md_a  = a;
        md_b  = b;
        step();
        start = MD_NONE;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (inject && cnt == 1) begin
                md_wr    = MD_WR_LO;
                md_wdata = 32'h0000_ABCD;
                start    = MD_DIV;
                md_a     = 32'h1234_5678;
                md_b     = 32'h0000_0009;
            end else if (inject && cnt == 2) begin
                md_wr = MD_WR_NONE;
                start = MD_NONE;
            end
            step();
        end
        check({tag, "_busy_cycles"}, 32'(cnt), 32'(n));
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
        rd_hi = 1'b1;
        #1;
        check({tag, "_mfhi"}, md_out, eh);
        rd_hi = 1'b0;
        #1;
        check({tag, "_mflo"}, md_out, el);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = MD_NONE;
        md_a     = 32'd0;
        md_b     = 32'd0;
        md_wr    = MD_WR_NONE;
        md_wdata = 32'd0;
        rd_hi    = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_md_out", md_out, 32'd0);

        do_op("mult", MD_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        do_op("multu", MD_MULTU, 32'hFFFF_FFFD, 32'd5, 5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0);
        do_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
        do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);

        // mthi / mtlo, then divide by zero leaves them untouched
        md_wr = MD_WR_HI; md_wdata = 32'h11;
        step();
        check("mthi_vis", hi, 32'h11);
        md_wr = MD_WR_LO; md_wdata = 32'h22;
        step();
        md_wr = MD_WR_NONE;
        check("mtlo_vis", lo, 32'h22);
        check("mtlo_keeps_hi", hi, 32'h11);
        do_op("div0", MD_DIV, 32'd9, 32'd0, 10, 32'h11, 32'h22, 1'b0);

        // inputs during RUN are ignored
        do_op("run_ignore", MD_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);

        // same-cycle start and mthi in IDLE: write dropped
        md_wr = MD_WR_HI; md_wdata = 32'h0000_DEAD;
        start = MD_MULT; md_a = 32'd7; md_b = 32'd8;
        step();
        md_wr = MD_WR_NONE; start = MD_NONE;
        check("start_wr_busy", {31'd0, busy}, 32'd1);
        check("start_wr_hi_dropped", hi, 32'd0);
        for (int i = 0; i < 6 && busy; i++) step();
        check("start_wr_lo", lo, 32'd56);

        // reserved start code
        start = 3'd5;
        step();
        start = MD_NONE;
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_lo", lo, 32'd56);

        // reset at busy cycle 4 of divu
        md_wr = MD_WR_HI; md_wdata = 32'h55;
        step();
        md_wr = MD_WR_NONE;
        start = MD_DIVU; md_a = 32'd100; md_b = 32'd7;
        step();
        start = MD_NONE;
        step();
        step();
        step();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        check("mid_rst_md_out", md_out, 32'd0);
        do_op("after_rst", MD_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b0);

        // back-to-back: second start in the first non-busy cycle
        do_op("b2b_1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd0, 32'd1, 1'b0);
        do_op("b2b_2", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'd1, 1'b0);

        // rd_hi toggling within one cycle
        md_wr = MD_WR_HI; md_wdata = 32'hCAFE_0001;
        step();
        md_wr = MD_WR_NONE;
        rd_hi = 1'b1; #1;
        check("rd_toggle_hi", md_out, 32'hCAFE_0001);
        rd_hi = 1'b0; #1;
        check("rd_toggle_lo", md_out, 32'd1);
        rd_hi = 1'b1; #1;
        check("rd_toggle_hi2", md_out, 32'hCAFE_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
